bfly_dif_seq: RTL and testbench

Pipelined radix-2 decimation-in-frequency butterfly: the add/subtract happens before the twiddle multiply, the mirror of the DIT butterflies. It is the building block for the inverse-transform datapath and for DIF-ordered forward stages. A valid/ready handshake and a 3-deep pipeline let one instance be time-shared across all butterflies of a stage by a sequencer. Samples and outputs are 8-bit signed. Twiddles are Q1.6, where 64 = 1.0.

---
 rtl/bfly_dif_seq_if.sv | 34 +++
 rtl/bfly_dif_seq.sv | 155 +++++++++++++++
 tb/tb_bfly_dif_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bfly_dif_seq_if.sv
// Handshake and data bundle for the radix-2 DIF butterfly.
// The master side offers sample pairs plus twiddle and takes results;
// the slave side is the butterfly itself.
interface bfly_dif_seq_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] xr0;
  logic signed [DATA_W-1:0] xi0;
  logic signed [DATA_W-1:0] xr1;
  logic signed [DATA_W-1:0] xi1;
  logic signed [COEF_W-1:0] wr;
  logic signed [COEF_W-1:0] wi;
  logic                     inv;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] yr0;
  logic signed [DATA_W-1:0] yi0;
  logic signed [DATA_W-1:0] yr1;
  logic signed [DATA_W-1:0] yi1;
  logic                     ovf;

  modport master (
    output in_valid, xr0, xi0, xr1, xi1, wr, wi, inv, out_ready,
    input  in_ready, out_valid, yr0, yi0, yr1, yi1, ovf
  );

  modport slave (
    input  in_valid, xr0, xi0, xr1, xi1, wr, wi, inv, out_ready,
    output in_ready, out_valid, yr0, yi0, yr1, yi1, ovf
  );
endinterface

// File: rtl/bfly_dif_seq.sv
// Pipelined radix-2 decimation-in-frequency butterfly.
//   y0 = scale(x0 + x1), y1 = scale((x0 - x1) * w'), w' = conj(w) when inv=1.
// Three register stages (sum/diff, products, round/saturate) share one
// advance enable so bubbles travel with the data and a stalled output
// freezes the whole pipe.
module bfly_dif_seq #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int SCALE  = 0
) (
  input logic           clk,
  input logic           rst,
  bfly_dif_seq_if.slave bus
);

  // Sum/difference width, widened twiddle width, product and accumulate widths.
  localparam int S_W  = DATA_W + 1;
  localparam int W_W  = COEF_W + 1;
  localparam int P_W  = S_W + W_W;
  localparam int T_W  = P_W + 1;
  // Twiddle fraction bits: Q1.(COEF_W-2), so 2^FRAC represents 1.0.
  localparam int FRAC = COEF_W - 2;

  localparam logic signed [T_W:0] MAXV   = (T_W+1)'(2**(DATA_W-1) - 1);
  localparam logic signed [T_W:0] MINV   = (T_W+1)'(-(2**(DATA_W-1)));
  localparam logic signed [T_W:0] T_HALF = (T_W+1)'(2**(FRAC-1+SCALE));
  localparam logic signed [T_W:0] A_HALF = (T_W+1)'(SCALE);

  // Round half up, then drop the twiddle fraction plus the optional halving.
  function automatic logic signed [T_W:0] rnd_t(input logic signed [T_W-1:0] t);
    logic signed [T_W:0] s;
    s = (T_W+1)'(t) + T_HALF;
    return s >>> (FRAC + SCALE);
  endfunction

  // Round half up for the optional halving of the sum path.
  function automatic logic signed [T_W:0] rnd_a(input logic signed [S_W-1:0] a);
    logic signed [T_W:0] s;
    s = (T_W+1)'(a) + A_HALF;
    return s >>> SCALE;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [T_W:0] v);
    if (v > MAXV) return MAXV[DATA_W-1:0];
    if (v < MINV) return MINV[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [T_W:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  logic adv;
  logic vld_p0, vld_p1, vld_p2;

  logic signed [S_W-1:0] ar_c, ai_c, br_c, bi_c;
  logic signed [W_W-1:0] wr_c, wi_c, we_c;

  logic signed [S_W-1:0] ar_p0, ai_p0, br_p0, bi_p0;
  logic signed [W_W-1:0] wr_p0, we_p0;

  logic signed [P_W-1:0] p_brwr_p1, p_biwe_p1, p_brwe_p1, p_biwr_p1;
  logic signed [S_W-1:0] ar_p1, ai_p1;

  logic signed [T_W-1:0] tr_c, ti_c;
  logic signed [T_W:0]   yr0_w, yi0_w, yr1_w, yi1_w;
  logic                  clip_c;

  logic signed [DATA_W-1:0] yr0_p2, yi0_p2, yr1_p2, yi1_p2;
  logic                     ovf_q;

  // A free output slot (or one being drained) lets every stage move.
  assign adv          = !vld_p2 || bus.out_ready;
  assign bus.in_ready = adv;

  assign ar_c = S_W'(bus.xr0) + S_W'(bus.xr1);
  assign ai_c = S_W'(bus.xi0) + S_W'(bus.xi1);
  assign br_c = S_W'(bus.xr0) - S_W'(bus.xr1);
  assign bi_c = S_W'(bus.xi0) - S_W'(bus.xi1);
  assign wr_c = W_W'(bus.wr);
  assign wi_c = W_W'(bus.wi);
  // One extra bit keeps -(-2^(COEF_W-1)) exact.
  assign we_c = bus.inv ? -wi_c : wi_c;

  // Valid bits shift with the data; rst flushes every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= bus.in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- Stage S1: sum/difference and conjugate-aware twiddle capture ----
  always_ff @(posedge clk) begin
    if (adv) begin
      ar_p0 <= ar_c;
      ai_p0 <= ai_c;
      br_p0 <= br_c;
      bi_p0 <= bi_c;
      wr_p0 <= wr_c;
      we_p0 <= we_c;
    end
  end

  // ---- Stage S2: four partial products, sum path delayed alongside ----
  always_ff @(posedge clk) begin
    if (adv) begin
      p_brwr_p1 <= P_W'(br_p0) * P_W'(wr_p0);
      p_biwe_p1 <= P_W'(bi_p0) * P_W'(we_p0);
      p_brwe_p1 <= P_W'(br_p0) * P_W'(we_p0);
      p_biwr_p1 <= P_W'(bi_p0) * P_W'(wr_p0);
      ar_p1     <= ar_p0;
      ai_p1     <= ai_p0;
    end
  end

  assign tr_c   = T_W'(p_brwr_p1) - T_W'(p_biwe_p1);
  assign ti_c   = T_W'(p_brwe_p1) + T_W'(p_biwr_p1);
  assign yr0_w  = rnd_a(ar_p1);
  assign yi0_w  = rnd_a(ai_p1);
  assign yr1_w  = rnd_t(tr_c);
  assign yi1_w  = rnd_t(ti_c);
  assign clip_c = clipped(yr0_w) | clipped(yi0_w) | clipped(yr1_w) | clipped(yi1_w);

  // ---- Stage S3: round, saturate and register outputs; sticky overflow ----
  // Only real beats load the outputs, so bubbles never disturb them or ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      yr0_p2 <= '0;
      yi0_p2 <= '0;
      yr1_p2 <= '0;
      yi1_p2 <= '0;
      ovf_q  <= 1'b0;
    end else if (adv && vld_p1) begin
      yr0_p2 <= sat(yr0_w);
      yi0_p2 <= sat(yi0_w);
      yr1_p2 <= sat(yr1_w);
      yi1_p2 <= sat(yi1_w);
      if (clip_c) ovf_q <= 1'b1;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.yr0       = yr0_p2;
  assign bus.yi0       = yi0_p2;
  assign bus.yr1       = yr1_p2;
  assign bus.yi1       = yi1_p2;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bfly_dif_seq.sv
// Bench for bfly_dif_seq: two instances (SCALE=0 and SCALE=1) see the same
// stimulus; a reference model fills one scoreboard queue per instance on
// every accepted beat and each output transfer is popped and compared.
module tb_bfly_dif_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid, inv, out_ready;
  logic signed [7:0] xr0, xi0, xr1, xi1, wr, wi;
  logic              bp_en;
  int                bp_cnt;

  bfly_dif_seq_if bus0 ();
  bfly_dif_seq_if bus1 ();

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.xr0 = xr0;            assign bus1.xr0 = xr0;
  assign bus0.xi0 = xi0;            assign bus1.xi0 = xi0;
  assign bus0.xr1 = xr1;            assign bus1.xr1 = xr1;
  assign bus0.xi1 = xi1;            assign bus1.xi1 = xi1;
  assign bus0.wr  = wr;             assign bus1.wr  = wr;
  assign bus0.wi  = wi;             assign bus1.wi  = wi;
  assign bus0.inv = inv;            assign bus1.inv = inv;
  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;

  bfly_dif_seq #(.SCALE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bfly_dif_seq #(.SCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int yr0, yi0, yr1, yi1;
    bit clip;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   exp_ovf [2];
  bit   prev_stall [2];
  int   held [2][4];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic bit outside8(input int v);
    return (v > 127) || (v < -128);
  endfunction

  // Reference: integer math, round half up, arithmetic shift, clamp.
  function automatic exp_t model(input int sc, input int a0r, input int a0i,
                                 input int a1r, input int a1i, input int w_r,
                                 input int w_i, input bit iv);
    exp_t e;
    int sr, si, dr, di, we, tr, ti, r0, i0, r1, i1;
    sr = a0r + a1r;  si = a0i + a1i;
    dr = a0r - a1r;  di = a0i - a1i;
    we = iv ? -w_i : w_i;
    tr = dr * w_r - di * we;
    ti = dr * we + di * w_r;
    r0 = (sr + sc) >>> sc;
    i0 = (si + sc) >>> sc;
    r1 = (tr + (1 << (5 + sc))) >>> (6 + sc);
    i1 = (ti + (1 << (5 + sc))) >>> (6 + sc);
    e.yr0 = clamp8(r0); e.yi0 = clamp8(i0);
    e.yr1 = clamp8(r1); e.yi1 = clamp8(i1);
    e.clip = outside8(r0) | outside8(i0) | outside8(r1) | outside8(i1);
    return e;
  endfunction

  function automatic int qsize(input int sc);
    return (sc == 0) ? q0.size() : q1.size();
  endfunction

  // Per-instance monitor step, sampled on the falling edge.
  task automatic mon(input int sc, input logic ir, input logic ov,
                     input logic signed [7:0] a, input logic signed [7:0] b,
                     input logic signed [7:0] c, input logic signed [7:0] d,
                     input logic of);
    exp_t e;
    if (rst) begin
      if (sc == 0) q0.delete(); else q1.delete();
      exp_ovf[sc] = 1'b0;
      prev_stall[sc] = 1'b0;
      return;
    end
    if (prev_stall[sc]) begin
      chk($sformatf("s%0d_hold_valid", sc), int'(ov), 1);
      chk($sformatf("s%0d_hold_yr0", sc), int'(a), held[sc][0]);
      chk($sformatf("s%0d_hold_yi0", sc), int'(b), held[sc][1]);
      chk($sformatf("s%0d_hold_yr1", sc), int'(c), held[sc][2]);
      chk($sformatf("s%0d_hold_yi1", sc), int'(d), held[sc][3]);
    end
    prev_stall[sc] = 1'b0;
    if (ov) begin
      if (qsize(sc) == 0) begin
        chk($sformatf("s%0d_spurious_out", sc), 1, 0);
      end else if (!out_ready) begin
        chk($sformatf("s%0d_stall_in_ready", sc), int'(ir), 0);
        prev_stall[sc] = 1'b1;
        held[sc][0] = int'(a); held[sc][1] = int'(b);
        held[sc][2] = int'(c); held[sc][3] = int'(d);
      end else begin
        e = (sc == 0) ? q0.pop_front() : q1.pop_front();
        exp_ovf[sc] = exp_ovf[sc] | e.clip;
        chk($sformatf("s%0d_yr0", sc), int'(a), e.yr0);
        chk($sformatf("s%0d_yi0", sc), int'(b), e.yi0);
        chk($sformatf("s%0d_yr1", sc), int'(c), e.yr1);
        chk($sformatf("s%0d_yi1", sc), int'(d), e.yi1);
        chk($sformatf("s%0d_ovf", sc), int'(of), int'(exp_ovf[sc]));
      end
    end else begin
      chk($sformatf("s%0d_idle_in_ready", sc), int'(ir), 1);
    end
    if (in_valid && ir) begin
      e = model(sc, xr0, xi0, xr1, xi1, wr, wi, inv);
      if (sc == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.in_ready, bus0.out_valid, bus0.yr0, bus0.yi0, bus0.yr1, bus0.yi1, bus0.ovf);
    mon(1, bus1.in_ready, bus1.out_valid, bus1.yr0, bus1.yi0, bus1.yr1, bus1.yi1, bus1.ovf);
  end

  // Downstream ready: always 1, or the repeating 1,0,0 pattern under backpressure.
  initial begin
    out_ready = 1'b1;
    bp_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        out_ready = (bp_cnt % 3 == 0);
        bp_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int a0r, input int a0i, input int a1r, input int a1i,
                          input int w_r, input int w_i, input bit iv);
    xr0 = 8'(a0r); xi0 = 8'(a0i); xr1 = 8'(a1r); xi1 = 8'(a1i);
    wr = 8'(w_r); wi = 8'(w_i); inv = iv;
  endtask

  // Offer one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input int a0r, input int a0i, input int a1r, input int a1i,
                           input int w_r, input int w_i, input bit iv);
    int n;
    set_beat(a0r, a0i, a1r, a1i, w_r, w_i, iv);
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus0.in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Single beat with exact 3-cycle latency check; starts and ends at posedge+1.
  task automatic lat_beat(input string tag, input int a0r, input int a0i,
                          input int a1r, input int a1i, input int w_r,
                          input int w_i, input bit iv);
    set_beat(a0r, a0i, a1r, a1i, w_r, w_i, iv);
    in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_accept"}, int'(bus0.in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("%s_lat%0d_s0", tag, k), int'(bus0.out_valid), int'(k == 3));
      chk($sformatf("%s_lat%0d_s1", tag, k), int'(bus1.out_valid), int'(k == 3));
    end
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q0.size() + q1.size(), 0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    bp_en = 1'b0;
    set_beat(0, 0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid_s0", int'(bus0.out_valid), 0);
    chk("rst_out_valid_s1", int'(bus1.out_valid), 0);
    chk("rst_yr0", int'(bus0.yr0), 0);
    chk("rst_yi0", int'(bus0.yi0), 0);
    chk("rst_yr1", int'(bus0.yr1), 0);
    chk("rst_yi1", int'(bus0.yi1), 0);
    chk("rst_ovf", int'(bus0.ovf), 0);
    chk("rst_in_ready", int'(bus0.in_ready), 1);
    tick();

    // Identity twiddle, with exact latency.
    lat_beat("ident", 10, 5, 3, -2, 64, 0, 1'b0);

    // Twiddle j, plain and conjugated, back to back.
    send_beat(10, 5, 3, -2, 0, 64, 1'b0);
    send_beat(10, 5, 3, -2, 0, 64, 1'b1);
    // Conjugate of the most negative twiddle.
    send_beat(20, -9, -30, 11, 5, -128, 1'b1);
    drain();

    // Saturation on the sum path (SCALE=0 clips, SCALE=1 halves cleanly).
    send_beat(100, 0, 100, 0, 64, 0, 1'b0);
    // Rounding of negatives.
    send_beat(0, 0, 7, 7, 64, 0, 1'b0);
    send_beat(-3, 0, 0, 0, 64, 0, 1'b0);
    drain();
    chk("ovf_sticky_s0", int'(bus0.ovf), 1);
    chk("ovf_clear_s1", int'(bus1.ovf), 0);

    // Backpressure: 8 beats streamed while out_ready runs 1,0,0,...
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++)
      send_beat(int'($signed(8'($urandom))), int'($signed(8'($urandom))),
                int'($signed(8'($urandom))), int'($signed(8'($urandom))),
                int'($signed(8'($urandom))), int'($signed(8'($urandom))), 1'($urandom));
    drain();
    bp_en = 1'b0;
    drain();

    // Reset with three beats in flight; in_valid stays high during rst.
    set_beat(1, 2, 3, 4, 64, 0, 1'b0);
    in_valid = 1'b1;
    tick();
    set_beat(5, 6, 7, 8, 64, 0, 1'b0);
    tick();
    set_beat(9, 10, 11, 12, 64, 0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid_s0", int'(bus0.out_valid), 0);
    chk("midrst_out_valid_s1", int'(bus1.out_valid), 0);
    chk("midrst_ovf_s0", int'(bus0.ovf), 0);
    repeat (6) @(negedge clk);
    tick();
    lat_beat("post_rst", -40, 17, 25, -60, 45, -45, 1'b1);

    // Random stream with bubbles and backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send_beat(int'($signed(8'($urandom))), int'($signed(8'($urandom))),
                int'($signed(8'($urandom))), int'($signed(8'($urandom))),
                int'($signed(8'($urandom))), int'($signed(8'($urandom))), 1'($urandom));
    end
    drain();
    bp_en = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
